// File: rtl/systolic_tile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_tile_ctrl
// Purpose  : Tile sequencer for the systolic array. It splits one matrix-op
//            command into A blocks and B tiles and drives the loader and PE phases.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_tile_ctrl #(
    parameter int SYS_CYCLES = 24,
    parameter int ACC_CYCLES = 4,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] cfg,
    input  logic       load_done,
    output logic       load_req,
    output logic [2:0] load_sel,
    output logic [1:0] tile_m,
    output logic [1:0] tile_n,
    output logic       sys_en,
    output logic       acc_en,
    output logic       resetA,
    output logic       resetB,
    output logic [3:0] state_o,
    output logic       busy,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_INIT_WAIT_A = 4'd1,
        S_INIT_WAIT_C = 4'd2,
        S_INIT_WAIT_B = 4'd3,
        S_SYSTOLIC    = 4'd4,
        S_ACCUMULATE  = 4'd5,
        S_WRITE_BACK  = 4'd6,
        S_RESET_B     = 4'd7,
        S_RESET_A     = 4'd8,
        S_FINISH      = 4'd9,
        S_READ_C      = 4'd10
    } state_t;

    localparam logic [3:0]       C_CFG_MAX  = 4'd11;
    localparam logic [CNT_W-1:0] C_SYS_LAST = CNT_W'(SYS_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ACC_LAST = CNT_W'(ACC_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cfg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_first;
    logic [1:0]         r_tile_m;
    logic [1:0]         r_tile_n;
    logic               r_cfg_err;

    logic [1:0]         w_na_m1;
    logic [1:0]         w_nb_m1;
    logic               w_need_acc;
    logic               w_accept;
    logic               w_entering;

    // Op codes are grouped four precisions by three shapes: m16n16, m8n32, m32n8.
    always_comb begin
        w_na_m1 = 2'd1;
        w_nb_m1 = 2'd1;
        case (r_cfg)
            4'd1, 4'd4, 4'd7, 4'd10: begin
                w_na_m1 = 2'd0;
                w_nb_m1 = 2'd3;
            end
            4'd2, 4'd5, 4'd8, 4'd11: begin
                w_na_m1 = 2'd3;
                w_nb_m1 = 2'd0;
            end
            default: begin
                w_na_m1 = 2'd1;
                w_nb_m1 = 2'd1;
            end
        endcase
    end

    assign w_need_acc = (r_cfg >= 4'd6);
    assign w_accept   = (r_state == S_IDLE) && start && (cfg <= C_CFG_MAX);
    assign w_entering = (w_state_nxt != r_state);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:        if (w_accept)  w_state_nxt = S_INIT_WAIT_A;
            S_INIT_WAIT_A: if (load_done) w_state_nxt = S_INIT_WAIT_C;
            S_INIT_WAIT_C: if (load_done) w_state_nxt = S_INIT_WAIT_B;
            S_INIT_WAIT_B: if (load_done) w_state_nxt = S_SYSTOLIC;
            S_SYSTOLIC:
                if (r_cnt == C_SYS_LAST)
                    w_state_nxt = w_need_acc ? S_ACCUMULATE : S_WRITE_BACK;
            S_ACCUMULATE:  if (r_cnt == C_ACC_LAST) w_state_nxt = S_WRITE_BACK;
            S_WRITE_BACK:
                if (load_done) begin
                    if (r_tile_n != w_nb_m1)      w_state_nxt = S_RESET_B;
                    else if (r_tile_m != w_na_m1) w_state_nxt = S_RESET_A;
                    else                          w_state_nxt = S_FINISH;
                end
            S_RESET_B:     w_state_nxt = S_INIT_WAIT_C;
            S_RESET_A:     w_state_nxt = S_INIT_WAIT_A;
            S_FINISH:      w_state_nxt = S_IDLE;
            default:       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cfg     <= 4'd0;
            r_cnt     <= '0;
            r_first   <= 1'b0;
            r_tile_m  <= 2'd0;
            r_tile_n  <= 2'd0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // The first-cycle flag lets load_req fire once per wait-state entry.
            r_first   <= w_entering;
            r_cfg_err <= (r_state == S_IDLE) && start && (cfg > C_CFG_MAX);
            if (w_entering)
                r_cnt <= '0;
            else if (r_state == S_SYSTOLIC || r_state == S_ACCUMULATE)
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_accept)
                r_cfg <= cfg;
            case (r_state)
                S_RESET_B: r_tile_n <= r_tile_n + 2'd1;
                S_RESET_A: begin
                    r_tile_m <= r_tile_m + 2'd1;
                    r_tile_n <= 2'd0;
                end
                S_FINISH: begin
                    r_tile_m <= 2'd0;
                    r_tile_n <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_sel = 3'b000;
        case (r_state)
            S_INIT_WAIT_A: load_sel = 3'b100;
            S_INIT_WAIT_B: load_sel = 3'b010;
            S_INIT_WAIT_C: load_sel = 3'b001;
            default:       load_sel = 3'b000;
        endcase
    end

    assign load_req = r_first && (r_state == S_INIT_WAIT_A || r_state == S_INIT_WAIT_C ||
                                  r_state == S_INIT_WAIT_B || r_state == S_WRITE_BACK);
    assign tile_m   = r_tile_m;
    assign tile_n   = r_tile_n;
    assign sys_en   = (r_state == S_SYSTOLIC);
    assign acc_en   = (r_state == S_ACCUMULATE);
    assign resetA   = (r_state == S_RESET_A);
    assign resetB   = (r_state == S_RESET_B);
    assign state_o  = r_state;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_FINISH);
    assign cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: doc/systolic_tile_ctrl.md
Name: systolic_tile_ctrl

Overview:
- Top-level sequencer for the tensor-core systolic array.
- Accepts one matrix-op command (full_type_t encoding), splits it into 8-row A blocks and 8-column B tiles, and drives the AXI loader through the A/C/B fills.
- Times the SYSTOLIC, ACCUMULATE and WRITE_BACK phases and pulses address-generator resets between tiles.
- Sits between the command/CSR interface, the AXI loader and the PE array / address generators.

Parameters:
- SYS_CYCLES, 24, cycles spent in SYSTOLIC per tile (8 rows + K=16 skew).
- ACC_CYCLES, 4, cycles spent in ACCUMULATE per tile (INT8/INT4 only).
- CNT_W, 6, width of internal phase cycle counter; must hold max(SYS_CYCLES, ACC_CYCLES).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command strobe; accepted only in IDLE.
- cfg  in  4  full_type_t op code (0..11), sampled with start.
- load_done  in  1  loader completion for the outstanding request.
- load_req  out  1  one-cycle pulse requesting a transfer.
- load_sel  out  3  transfer target: 100=A, 010=B, 001=C, 000=D store; held through the wait state.
- tile_m  out  2  current A-block index.
- tile_n  out  2  current B-tile index.
- sys_en  out  1  high throughout SYSTOLIC.
- acc_en  out  1  high throughout ACCUMULATE.
- resetA  out  1  one-cycle pulse in RESET_A.
- resetB  out  1  one-cycle pulse in RESET_B.
- state_o  out  4  state_t encoding of current state.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse in FINISH.
- cfg_err  out  1  one-cycle pulse the cycle after start with cfg>11.

Behaviour:
- Reset: all outputs 0; state IDLE; tile_m = tile_n = 0; latched cfg cleared. Reset mid-operation aborts immediately with no further load_req.
- Decode on start (latched):
  - Shape m16n16: nA=2, nB=2. m8n32: nA=1, nB=4. m32n8: nA=4, nB=1.
  - need_acc = 1 for INT8/INT4 (cfg 6..11), else 0.
- Wait states: load_req pulses on the first cycle of each INIT_WAIT_* and WRITE_BACK entry. load_done is accepted on any cycle of that state, including the request cycle. load_done in any other state is ignored.
- Transitions:
  - IDLE -start & cfg<=11-> INIT_WAIT_A (sel 100).
  - IDLE -start & cfg>11-> IDLE, with cfg_err pulse.
  - INIT_WAIT_A -done-> INIT_WAIT_C (sel 001).
  - INIT_WAIT_C -done-> INIT_WAIT_B (sel 010).
  - INIT_WAIT_B -done-> SYSTOLIC.
  - SYSTOLIC: exactly SYS_CYCLES cycles, then ACCUMULATE if need_acc, else WRITE_BACK.
  - ACCUMULATE: exactly ACC_CYCLES cycles, then WRITE_BACK (sel 000).
  - WRITE_BACK -done->:
    - tile_n<nB-1: RESET_B.
    - else tile_m<nA-1: RESET_A.
    - else FINISH.
  - RESET_B (1 cycle): tile_n++, then INIT_WAIT_C.
  - RESET_A (1 cycle): tile_m++, tile_n=0, then INIT_WAIT_A.
  - FINISH (1 cycle, done=1): clears indices, then IDLE.
- READ_C encoding is never produced by this block.
- start while busy: ignored; latched cfg unchanged.
- load_sel changes only on state entry. tile_m/tile_n change only in RESET_A/RESET_B/FINISH.
- Per command: load_req count = nA + 3·nA·nB; resetB count = nA·(nB-1); resetA count = nA-1.

Test Plan:
- Reset during SYSTOLIC of FP32_m16n16k16 → all outputs 0 and state_o=0 asynchronously; a new start then runs normally from tile 0.
- cfg=0 (FP32 m16n16), load_done returned the same cycle as each load_req → 14 load_req pulses with sel order 100,001,010,000,001,010,000,100,001,010,000,001,010,000; 2 resetB, 1 resetA, acc_en never high; done 1 cycle after last WRITE_BACK; total 1+2·(3+24+1)·2+... cycle count matches the FSM model exactly.
- cfg=7 (INT8 m8n32) → nA=1, nB=4; tile_n steps 0..3; acc_en high for exactly 4 cycles per tile; 13 load_req pulses; resetA never pulses.
- cfg=5 (FP16 m32n8), load_done delayed 5 cycles each → tile_m steps 0..3; 3 resetA pulses, no resetB; state holds in the wait states until load_done arrives.
- Invalid and overlapping strobes: cfg=12 → cfg_err pulse, busy stays 0. start with cfg=9 while busy → ignored and shape unchanged. Stray load_done in SYSTOLIC → no state change.
